alu_exec_unit: RTL
==================

// Module: alu_exec_unit
// PURPOSE
// - Sequential MIPS ALU execute stage: accepts one instruction word and two register operands
//   over a valid/ready handshake, then returns result c and flags over a second handshake.
// - Sits between decode/register-read and writeback. Serves as the responder to the ALU stimulus driver.
// - Same instruction subset as the combinational alu; shifts run iteratively to bound critical path.
// PARAMETERS
// - SHIFT_STEP  1  bits shifted per EXEC cycle; legal values 1, 2, 4
// PORTS
// - clk        in   1   clock, rising edge
// - rst_n      in   1   asynchronous active-low reset
// - in_valid   in   1   i_datain/gr1/gr2 valid
// - in_ready   out  1   unit can accept (high only in IDLE)
// - i_datain   in   32  instruction word: op=[31:26], shamt=[10:6], func=[5:0], imm=[15:0]
// - gr1        in   32  rs operand
// - gr2        in   32  rt operand
// - out_valid  out  1   c/flags/illegal valid
// - out_ready  in   1   consumer accepts result
// - c          out  32  result
// - flags      out  3   [2]=zero, [1]=negative, [0]=overflow
// - illegal    out  1   unsupported op/func
// BEHAVIOUR
// - Reset (async, rst_n=0): state=IDLE, in_ready=1, out_valid=0, c=0, flags=0, illegal=0.
// - FSM: IDLE -(in_valid)-> EXEC if shift with amount>0, else DONE; EXEC -(count done)-> DONE;
//   DONE -(out_ready)-> IDLE. Operands/instruction latched on accept; inputs ignored outside IDLE.
// - Latency: non-shift op accepted at edge T -> out_valid at T+1. Shift with amount n -> T+1+ceil(n/SHIFT_STEP).
// - Outputs held stable in DONE until out_ready; no new accept in the same cycle as DONE->IDLE.
// - R-type (op=0): add/addu/sub/subu/and/or/xor/nor/slt/sltu on gr1,gr2.
//   sll/srl/sra: gr2 shifted by shamt. sllv/srlv/srav: gr2 shifted by gr1[4:0].
// - I-type: addi/addiu/slti/sltiu/lw/sw use sign-extended imm; andi/ori/xori zero-extended.
//   lw/sw: c = gr1 + sext(imm). beq/bne: c = gr1 - gr2.
// - Width: all 32-bit, results truncated mod 2^32. slt/slti signed; sltu/sltiu unsigned
//   (sltiu compares against sign-extended imm). c = {31'b0, lt}.
// - zero = (c==0) for all ops. negative = c[31], except slt family, where negative = lt.
// - overflow: signed overflow for add, addi, sub only; 0 for all other ops.
// - Illegal op/func: illegal=1, c=0, flags=000. Latency 1.
// - Shift amount 0 (any shift): c = gr2, latency 1. Shift amount 31: complete.
//   sra fills with the sign bit of gr2.
// - rst_n low mid-EXEC aborts the shift; returns to reset state immediately; partial result is discarded.
// CONFIGURATION
// - ALU_SHIFT_FAST_EN defined: shifts use a single-cycle barrel shifter, EXEC is never entered,
//   and all ops have latency 1. SHIFT_STEP is ignored.
// - ALU_SHIFT_FAST_EN undefined: iterative shifter with SHIFT_STEP bits per cycle, as above.
// STRUCTURE
// - Package alu_pkg: opcode localparams (OP_RTYPE=6'h00, OP_ADDI=6'h08, OP_ADDIU=6'h09, OP_SLTI=6'h0a,
//   OP_SLTIU=6'h0b, OP_ANDI=6'h0c, OP_ORI=6'h0d, OP_XORI=6'h0e, OP_BEQ=6'h04, OP_BNE=6'h05,
//   OP_LW=6'h23, OP_SW=6'h2b).
// - Package alu_pkg: funct localparams (add 20, addu 21, sub 22, subu 23, and 24, or 25, xor 26,
//   nor 27, slt 2a, sltu 2b, sll 00, srl 02, sra 03, sllv 04, srlv 06, srav 07).
// - Package alu_pkg: state enum {IDLE, EXEC, DONE}; flag bit index constants.
// - Sub-module alu_shift_iter: load/value/amount/dir/arith in; done/result out; owns its counter.
// TESTING
// - add: gr1=00000001, gr2=00000009 -> c=0000000a, flags=000, out_valid at T+1.
// - add: gr1=gr2=80000001 -> c=00000002, flags=001 (overflow).
//   addi, imm=8020, gr1=80000001 -> c=7fff8021, flags=001.
// - beq: gr1=gr2=80000001 -> c=0, flags=100.
//   slt: gr1=80000000, gr2=ffffffff -> c=1, flags=010.
//   sltu, same operands -> c=1, flags=000.
// - sra: shamt=1, gr2=fc200000 -> c=fe100000, out_valid at T+2 (SHIFT_STEP=1).
//   srlv: gr1=00000020 -> amount 0, c=gr2.
// - Backpressure: out_ready=0 for 5 cycles -> c/flags stable, in_ready=0.
//   Reset asserted during a 16-cycle sllv -> out_valid=0, in_ready=1 immediately.
// - Illegal: op=3f -> illegal=1, c=00000000, flags=000.
//   Repeat all cases with ALU_SHIFT_FAST_EN -> every latency is 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode/funct constants, FSM state type and flag helpers for the ALU execute stage.
// Combinational helpers only; no state.
// Not applicable: no handshake in this file.
package alu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ADDIU = 6'h09;
  localparam logic [5:0] OP_SLTI  = 6'h0a;
  localparam logic [5:0] OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_XORI  = 6'h0e;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;

  localparam logic [5:0] F_SLL  = 6'h00;
  localparam logic [5:0] F_SRL  = 6'h02;
  localparam logic [5:0] F_SRA  = 6'h03;
  localparam logic [5:0] F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06;
  localparam logic [5:0] F_SRAV = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_NOR  = 6'h27;
  localparam logic [5:0] F_SLT  = 6'h2a;
  localparam logic [5:0] F_SLTU = 6'h2b;

  localparam int FLAG_ZERO = 2;
  localparam int FLAG_NEG  = 1;
  localparam int FLAG_OVF  = 0;

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  // For signed set-less-than the result is 0/1, so "negative" reports the comparison itself.
  function automatic logic [2:0] flags_of(input logic [31:0] value, input logic lt_sel,
                                          input logic ovf);
    logic [2:0] f;
    f            = '0;
    f[FLAG_ZERO] = (value == '0);
    f[FLAG_NEG]  = lt_sel ? value[0] : value[31];
    f[FLAG_OVF]  = ovf;
    return f;
  endfunction

  // if/else rather than ?: so the arithmetic shift keeps its signed context.
  function automatic logic [31:0] shift_by(input logic [31:0] value, input logic [4:0] amt,
                                           input logic left, input logic arith);
    logic signed [31:0] sv;
    logic [31:0]        r;
    sv = $signed(value) >>> amt;
    if (left)       r = value << amt;
    else if (arith) r = sv;
    else            r = value >> amt;
    return r;
  endfunction

endpackage

// File: rtl/alu_shift_iter.sv
// Iterative 32-bit shifter: moves up to SHIFT_STEP bit positions per cycle after a load.
// Latency: ceil(amount/SHIFT_STEP) cycles after load; done flags the cycle of the final step.
// No backpressure: runs to completion once loaded; a new load restarts it.
module alu_shift_iter
  import alu_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] value,
  input  logic [4:0]  amount,
  input  logic        dir,
  input  logic        arith,
  output logic        done,
  output logic [31:0] result
);

  localparam logic [4:0] STEP_W = 5'(SHIFT_STEP);

  logic [31:0] value_q;
  logic [4:0]  cnt_q;
  logic [4:0]  stp;
  logic        left_q;
  logic        arith_q;

  assign stp = (cnt_q < STEP_W) ? cnt_q : STEP_W;
  // result is the value after this cycle's step, so the final step can be captured directly.
  assign result = shift_by(value_q, stp, left_q, arith_q);
  assign done   = (cnt_q != '0) && (cnt_q <= STEP_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value_q <= '0;
      cnt_q   <= '0;
      left_q  <= 1'b0;
      arith_q <= 1'b0;
    end else if (load) begin
      value_q <= value;
      cnt_q   <= amount;
      left_q  <= dir;
      arith_q <= arith;
    end else if (cnt_q != '0) begin
      value_q <= result;
      cnt_q   <= cnt_q - stp;
    end
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Sequential MIPS ALU execute stage; ALU_SHIFT_FAST_EN selects a single-cycle barrel shifter.
// Latency: 1 cycle, or 1+ceil(n/SHIFT_STEP) for shifts by n>0 in the iterative build.
// Backpressure: result held in DONE until out_ready; in_ready only in IDLE.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int SHIFT_STEP = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] i_datain,
  input  logic [31:0] gr1,
  input  logic [31:0] gr2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] c,
  output logic [2:0]  flags,
  output logic        illegal
);

  state_t      state_q;
  logic [5:0]  op;
  logic [5:0]  fn;
  logic [4:0]  shamt;
  logic [31:0] imm_s;
  logic [31:0] imm_z;
  logic [31:0] sum;
  logic [31:0] diff;
  logic [31:0] sum_i;
  logic        add_ovf;
  logic        sub_ovf;
  logic        addi_ovf;
  logic        slt_ab;
  logic        slt_ai;
  logic        unused_rsrt;

  logic [31:0] res_c;
  logic [2:0]  res_flags;
  logic        res_ovf;
  logic        res_ill;
  logic        slt_fam;
  logic        is_shift;
  logic        sh_left;
  logic        sh_arith;
  logic [4:0]  sh_amt;
  logic        go_exec;
  logic        sh_done;
  logic [31:0] sh_result;

  assign op          = i_datain[31:26];
  assign fn          = i_datain[5:0];
  assign shamt       = i_datain[10:6];
  assign imm_s       = {{16{i_datain[15]}}, i_datain[15:0]};
  assign imm_z       = {16'h0000, i_datain[15:0]};
  assign unused_rsrt = ^i_datain[25:16];

  assign sum      = gr1 + gr2;
  assign diff     = gr1 - gr2;
  assign sum_i    = gr1 + imm_s;
  assign add_ovf  = (gr1[31] == gr2[31]) && (sum[31] != gr1[31]);
  assign sub_ovf  = (gr1[31] != gr2[31]) && (diff[31] != gr1[31]);
  assign addi_ovf = (gr1[31] == imm_s[31]) && (sum_i[31] != gr1[31]);
  assign slt_ab   = $signed(gr1) < $signed(gr2);
  assign slt_ai   = $signed(gr1) < $signed(imm_s);

  always_comb begin
    res_c    = '0;
    res_ovf  = 1'b0;
    res_ill  = 1'b0;
    slt_fam  = 1'b0;
    is_shift = 1'b0;
    sh_left  = 1'b0;
    sh_arith = 1'b0;
    sh_amt   = shamt;
    case (op)
      OP_RTYPE: begin
        case (fn)
          F_ADD:  begin res_c = sum;  res_ovf = add_ovf; end
          F_ADDU: res_c = sum;
          F_SUB:  begin res_c = diff; res_ovf = sub_ovf; end
          F_SUBU: res_c = diff;
          F_AND:  res_c = gr1 & gr2;
          F_OR:   res_c = gr1 | gr2;
          F_XOR:  res_c = gr1 ^ gr2;
          F_NOR:  res_c = ~(gr1 | gr2);
          F_SLT:  begin res_c = {31'b0, slt_ab}; slt_fam = 1'b1; end
          F_SLTU: res_c = {31'b0, (gr1 < gr2)};
          F_SLL:  begin is_shift = 1'b1; sh_left = 1'b1; end
          F_SRL:  is_shift = 1'b1;
          F_SRA:  begin is_shift = 1'b1; sh_arith = 1'b1; end
          F_SLLV: begin is_shift = 1'b1; sh_left = 1'b1; sh_amt = gr1[4:0]; end
          F_SRLV: begin is_shift = 1'b1; sh_amt = gr1[4:0]; end
          F_SRAV: begin is_shift = 1'b1; sh_arith = 1'b1; sh_amt = gr1[4:0]; end
          default: res_ill = 1'b1;
        endcase
      end
      OP_ADDI:          begin res_c = sum_i; res_ovf = addi_ovf; end
      OP_ADDIU:         res_c = sum_i;
      OP_SLTI:          begin res_c = {31'b0, slt_ai}; slt_fam = 1'b1; end
      OP_SLTIU:         res_c = {31'b0, (gr1 < imm_s)};
      OP_ANDI:          res_c = gr1 & imm_z;
      OP_ORI:           res_c = gr1 | imm_z;
      OP_XORI:          res_c = gr1 ^ imm_z;
      OP_LW, OP_SW:     res_c = sum_i;
      OP_BEQ, OP_BNE:   res_c = diff;
      default:          res_ill = 1'b1;
    endcase
`ifdef ALU_SHIFT_FAST_EN
    if (is_shift) res_c = shift_by(gr2, sh_amt, sh_left, sh_arith);
`else
    // Only reached for a zero shift; non-zero amounts finish in the iterative shifter.
    if (is_shift) res_c = gr2;
`endif
    res_flags = res_ill ? 3'b000 : flags_of(res_c, slt_fam, res_ovf);
  end

`ifdef ALU_SHIFT_FAST_EN
  assign go_exec   = 1'b0;
  assign sh_done   = 1'b0;
  assign sh_result = '0;
`else
  assign go_exec = is_shift && (sh_amt != '0);

  alu_shift_iter #(
    .SHIFT_STEP(SHIFT_STEP)
  ) u_shift (
    .clk    (clk),
    .rst_n  (rst_n),
    .load   ((state_q == IDLE) && in_valid && go_exec),
    .value  (gr2),
    .amount (sh_amt),
    .dir    (sh_left),
    .arith  (sh_arith),
    .done   (sh_done),
    .result (sh_result)
  );
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      c         <= '0;
      flags     <= '0;
      illegal   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            in_ready <= 1'b0;
            if (go_exec) begin
              state_q <= EXEC;
            end else begin
              state_q   <= DONE;
              out_valid <= 1'b1;
              c         <= res_c;
              flags     <= res_flags;
              illegal   <= res_ill;
            end
          end
        end
        EXEC: begin
          if (sh_done) begin
            state_q   <= DONE;
            out_valid <= 1'b1;
            c         <= sh_result;
            flags     <= flags_of(sh_result, 1'b0, 1'b0);
            illegal   <= 1'b0;
          end
        end
        DONE: begin
          // in_ready rises only after this edge, so no accept overlaps the release.
          if (out_ready) begin
            state_q   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end
        end
        default: begin
          state_q   <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
